oven_timekeeper: RTL and testbench

OVEN_TIMEKEEPER -- requirements
Module: oven_timekeeper

---
 rtl/oven_timekeeper.sv | 159 +++++++++++++++
 tb/tb_oven_timekeeper.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oven_timekeeper.sv
`default_nettype none
// ============================================================================
// Module   : oven_timekeeper
// Brief    : Time-of-day clock (24h or 12h BCD display) with a minute cook timer.
// Revision : 1.0
// ============================================================================
module oven_timekeeper #(
    parameter int TICK_DIV    = 50000000,
    parameter int SEC_PER_MIN = 60,
    parameter bit MODE_12H    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       onOff,
    input  logic       set_mode,
    input  logic       inc_min,
    input  logic       inc_hour,
    input  logic       timer_load,
    input  logic       timer_cancel,
    input  logic [6:0] timer_min,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hour_lo,
    output logic [3:0] hour_hi,
    output logic       pm,
    output logic       sec_tick,
    output logic [3:0] tmr_lo,
    output logic [3:0] tmr_hi,
    output logic       timer_running,
    output logic       timer_alarm,
    output logic       timer_done
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SEC_PER_MIN > 2) ? $clog2(SEC_PER_MIN) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE = PW'(1);
    localparam logic [SW-1:0] SEC_MAX   = SW'(SEC_PER_MIN - 1);
    localparam logic [SW-1:0] SEC_ONE   = SW'(1);
    localparam logic [4:0]    HOUR_RST  = MODE_12H ? 5'd12 : 5'd0;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_RUN  = 2'd1;
    localparam logic [1:0] T_DONE = 2'd2;

    logic [PW-1:0] r_presc;
    logic [SW-1:0] r_sec;
    logic [5:0]    r_min;
    logic [4:0]    r_hour;
    logic          r_pm;
    logic          r_tick;
    logic [1:0]    r_tstate;
    logic [6:0]    r_trem;
    logic [SW-1:0] r_tsec;
    logic          r_tdone;

    logic w_run;
    logic w_wrap;
    logic w_sec_wrap;
    logic w_set_min;
    logic w_set_hour;
    logic w_min_step;
    logic w_hour_step;

    // Hours are kept in binary: 0..23, or 1..12 when the 12-hour display is selected.
    function automatic logic [4:0] hour_next(input logic [4:0] h);
        if (MODE_12H)
            return (h == 5'd12) ? 5'd1 : h + 5'd1;
        else
            return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    assign w_run       = onOff & ~set_mode;
    assign w_wrap      = w_run && (r_presc == PRESC_MAX);
    assign w_sec_wrap  = w_wrap && (r_sec == SEC_MAX);
    assign w_set_min   = set_mode & onOff & inc_min;
    assign w_set_hour  = set_mode & onOff & inc_hour;
    assign w_min_step  = w_sec_wrap | w_set_min;
    assign w_hour_step = (w_sec_wrap && (r_min == 6'd59)) | w_set_hour;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_sec   <= '0;
            r_tick  <= 1'b0;
            r_min   <= 6'd0;
            r_hour  <= HOUR_RST;
            r_pm    <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (set_mode) begin
                r_presc <= '0;
                r_sec   <= '0;
            end else if (w_run) begin
                if (w_wrap) begin
                    r_presc <= '0;
                    r_sec   <= w_sec_wrap ? '0 : r_sec + SEC_ONE;
                end else begin
                    r_presc <= r_presc + PRESC_ONE;
                end
            end
            if (w_min_step)
                r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
            if (w_hour_step) begin
                r_hour <= hour_next(r_hour);
                if (MODE_12H && (r_hour == 5'd11))
                    r_pm <= ~r_pm;
            end
        end
    end

    // Cancel outranks load; a fresh load discards any tick landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tstate <= T_IDLE;
            r_trem   <= 7'd0;
            r_tsec   <= '0;
            r_tdone  <= 1'b0;
        end else begin
            r_tdone <= 1'b0;
            if (timer_cancel) begin
                r_tstate <= T_IDLE;
                r_trem   <= 7'd0;
                r_tsec   <= '0;
            end else if (timer_load && (timer_min != 7'd0)) begin
                r_tstate <= T_RUN;
                r_trem   <= (timer_min > 7'd99) ? 7'd99 : timer_min;
                r_tsec   <= '0;
            end else if ((r_tstate == T_RUN) && w_wrap) begin
                if (r_tsec == SEC_MAX) begin
                    r_tsec <= '0;
                    r_trem <= r_trem - 7'd1;
                    if (r_trem == 7'd1) begin
                        r_tstate <= T_DONE;
                        r_tdone  <= 1'b1;
                    end
                end else begin
                    r_tsec <= r_tsec + SEC_ONE;
                end
            end
        end
    end

    assign {min_hi, min_lo}   = to_bcd({1'b0, r_min});
    assign {hour_hi, hour_lo} = to_bcd({2'b00, r_hour});
    assign {tmr_hi, tmr_lo}   = to_bcd(r_trem);
    assign pm                 = r_pm;
    assign sec_tick           = r_tick;
    assign timer_running      = (r_tstate == T_RUN);
    assign timer_alarm        = (r_tstate == T_DONE);
    assign timer_done         = r_tdone;

endmodule
`default_nettype wire

// File: tb/tb_oven_timekeeper.sv
`default_nettype none
// Bench for oven_timekeeper: a 24h and a 12h build share stimulus and are
// compared every cycle against a minute-of-day / seconds-left model.
module tb_oven_timekeeper;

    localparam int TD  = 4;
    localparam int SPM = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       onOff = 1'b0;
    logic       set_mode = 1'b0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic       timer_load = 1'b0;
    logic       timer_cancel = 1'b0;
    logic [6:0] timer_min = 7'd0;

    logic [3:0] a_min_lo, a_min_hi, a_hour_lo, a_hour_hi, a_tmr_lo, a_tmr_hi;
    logic       a_pm, a_sec_tick, a_timer_running, a_timer_alarm, a_timer_done;
    logic [3:0] b_min_lo, b_min_hi, b_hour_lo, b_hour_hi, b_tmr_lo, b_tmr_hi;
    logic       b_pm, b_sec_tick, b_timer_running, b_timer_alarm, b_timer_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    // model state
    int m_mod = 0;
    int m_run = 0;
    int m_tstate = 0;
    int m_left = 0;
    bit m_tick = 1'b0;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    oven_timekeeper #(.TICK_DIV(TD), .SEC_PER_MIN(SPM), .MODE_12H(1'b0)) dut24 (
        .clk(clk), .reset(reset), .onOff(onOff), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hour(inc_hour), .timer_load(timer_load),
        .timer_cancel(timer_cancel), .timer_min(timer_min),
        .min_lo(a_min_lo), .min_hi(a_min_hi), .hour_lo(a_hour_lo), .hour_hi(a_hour_hi),
        .pm(a_pm), .sec_tick(a_sec_tick), .tmr_lo(a_tmr_lo), .tmr_hi(a_tmr_hi),
        .timer_running(a_timer_running), .timer_alarm(a_timer_alarm), .timer_done(a_timer_done)
    );

    oven_timekeeper #(.TICK_DIV(TD), .SEC_PER_MIN(SPM), .MODE_12H(1'b1)) dut12 (
        .clk(clk), .reset(reset), .onOff(onOff), .set_mode(set_mode),
        .inc_min(inc_min), .inc_hour(inc_hour), .timer_load(timer_load),
        .timer_cancel(timer_cancel), .timer_min(timer_min),
        .min_lo(b_min_lo), .min_hi(b_min_hi), .hour_lo(b_hour_lo), .hour_hi(b_hour_hi),
        .pm(b_pm), .sec_tick(b_sec_tick), .tmr_lo(b_tmr_lo), .tmr_hi(b_tmr_hi),
        .timer_running(b_timer_running), .timer_alarm(b_timer_alarm), .timer_done(b_timer_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bcd4(input int hh, input int mm);
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    // Model: time is a minute of the day; seconds and prescaler are a single
    // count of enabled cycles since the last restart; the timer counts seconds left.
    always @(posedge clk) begin : model
        int h, mm, ld;
        bit tk;
        if (reset) begin
            m_mod = 0; m_run = 0; m_tstate = 0; m_left = 0; m_tick = 1'b0; m_done = 1'b0;
        end else begin
            tk = 1'b0;
            if (set_mode) begin
                m_run = 0;
            end else if (onOff) begin
                m_run++;
                if (m_run % TD == 0) begin
                    tk = 1'b1;
                    if ((m_run / TD) % SPM == 0) m_mod = (m_mod + 1) % 1440;
                end
            end
            if (set_mode && onOff && (inc_min || inc_hour)) begin
                h = m_mod / 60; mm = m_mod % 60;
                if (inc_min)  mm = (mm + 1) % 60;
                if (inc_hour) h = (h + 1) % 24;
                m_mod = h * 60 + mm;
            end
            m_done = 1'b0;
            if (timer_cancel) begin
                m_tstate = 0; m_left = 0;
            end else if (timer_load && timer_min != 7'd0) begin
                ld = int'(timer_min);
                if (ld > 99) ld = 99;
                m_tstate = 1; m_left = ld * SPM;
            end else if (m_tstate == 1 && tk) begin
                m_left--;
                if (m_left == 0) begin m_tstate = 2; m_done = 1'b1; end
            end
            m_tick = tk;
        end
    end

    always @(negedge clk) begin : cmp
        int h, h12, td;
        logic [7:0] et;
        if (check_en) begin
            h   = m_mod / 60;
            h12 = (h % 12 == 0) ? 12 : h % 12;
            td  = (m_tstate == 1) ? (m_left + SPM - 1) / SPM : 0;
            et  = {4'(td / 10), 4'(td % 10)};
            check("model_time24", 32'({a_hour_hi, a_hour_lo, a_min_hi, a_min_lo, a_pm}),
                  32'({bcd4(h, m_mod % 60), 1'b0}));
            check("model_time12", 32'({b_hour_hi, b_hour_lo, b_min_hi, b_min_lo, b_pm}),
                  32'({bcd4(h12, m_mod % 60), (h >= 12)}));
            check("model_timer24", 32'({a_tmr_hi, a_tmr_lo, a_timer_running, a_timer_alarm, a_timer_done, a_sec_tick}),
                  32'({et, (m_tstate == 1), (m_tstate == 2), m_done, m_tick}));
            check("model_timer12", 32'({b_tmr_hi, b_tmr_lo, b_timer_running, b_timer_alarm, b_timer_done, b_sec_tick}),
                  32'({et, (m_tstate == 1), (m_tstate == 2), m_done, m_tick}));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_inc(input bit mi, input bit hi);
        inc_min = mi; inc_hour = hi;
        @(negedge clk);
        inc_min = 1'b0; inc_hour = 1'b0;
    endtask

    task automatic pulse_tmr(input bit ld, input bit cn, input logic [6:0] tm);
        timer_min = tm; timer_load = ld; timer_cancel = cn;
        @(negedge clk);
        timer_load = 1'b0; timer_cancel = 1'b0;
    endtask

    initial begin
        int ticks, done_tick, dones;
        reset = 1'b1; onOff = 1'b0;
        step(2);
        check_en = 1'b1;
        check("rst_time24", 32'({a_hour_hi, a_hour_lo, a_min_hi, a_min_lo, a_pm}), 32'h0_0000);
        check("rst_time12", 32'({b_hour_hi, b_hour_lo, b_min_hi, b_min_lo, b_pm}), 32'({16'h1200, 1'b0}));
        check("rst_timer", 32'({a_tmr_hi, a_tmr_lo, a_timer_running, a_timer_alarm, a_timer_done, a_sec_tick}), 32'h0);

        // rollover: ticks on cycles 4 and 8, one minute after 8
        reset = 1'b0; onOff = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check($sformatf("tick_cycle%0d", i), 32'(a_sec_tick), 32'((i == 4) || (i == 8)));
        end
        check("rollover_min", 32'({a_hour_hi, a_hour_lo, a_min_hi, a_min_lo}), 32'h0001);

        // day wrap from 23:59
        set_mode = 1'b1;
        repeat (23) pulse_inc(1'b0, 1'b1);
        repeat (58) pulse_inc(1'b1, 1'b0);
        check("set_2359", 32'({a_hour_hi, a_hour_lo, a_min_hi, a_min_lo}), 32'h2359);
        check("set_1159pm", 32'({b_hour_hi, b_hour_lo, b_min_hi, b_min_lo, b_pm}), 32'({16'h1159, 1'b1}));
        set_mode = 1'b0;
        step(8);
        check("daywrap24", 32'({a_hour_hi, a_hour_lo, a_min_hi, a_min_lo, a_pm}), 32'h0_0000);
        check("daywrap12", 32'({b_hour_hi, b_hour_lo, b_min_hi, b_min_lo, b_pm}), 32'({16'h1200, 1'b0}));

        // 12h: 11:59am -> 12:00pm -> 01:00pm
        set_mode = 1'b1;
        repeat (11) pulse_inc(1'b0, 1'b1);
        repeat (59) pulse_inc(1'b1, 1'b0);
        check("set_1159am", 32'({b_hour_hi, b_hour_lo, b_min_hi, b_min_lo, b_pm}), 32'({16'h1159, 1'b0}));
        set_mode = 1'b0;
        step(8);
        check("noon12", 32'({b_hour_hi, b_hour_lo, b_min_hi, b_min_lo, b_pm}), 32'({16'h1200, 1'b1}));
        step(60 * SPM * TD);
        check("one_pm12", 32'({b_hour_hi, b_hour_lo, b_min_hi, b_min_lo, b_pm}), 32'({16'h0100, 1'b1}));
        check("one_pm24", 32'({a_hour_hi, a_hour_lo, a_min_hi, a_min_lo}), 32'h1300);

        // set mode: simultaneous inc at 10:59, then frozen
        set_mode = 1'b1;
        repeat (21) pulse_inc(1'b0, 1'b1);
        repeat (59) pulse_inc(1'b1, 1'b0);
        check("set_1059", 32'({a_hour_hi, a_hour_lo, a_min_hi, a_min_lo}), 32'h1059);
        pulse_inc(1'b1, 1'b1);
        check("both_inc", 32'({a_hour_hi, a_hour_lo, a_min_hi, a_min_lo}), 32'h1100);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("setmode_no_tick", 32'(a_sec_tick), 32'h0);
        end
        check("setmode_hold", 32'({a_hour_hi, a_hour_lo, a_min_hi, a_min_lo}), 32'h1100);

        // cook timer of 2 minutes
        set_mode = 1'b0;
        pulse_tmr(1'b1, 1'b0, 7'd2);
        check("tmr_load2", 32'({a_tmr_hi, a_tmr_lo, a_timer_running, a_timer_alarm}), 32'({8'h02, 2'b10}));
        ticks = 0; dones = 0; done_tick = -1;
        for (int i = 0; i < 100 && dones == 0; i++) begin
            step(1);
            if (a_sec_tick) ticks++;
            if (a_timer_done) begin dones++; done_tick = ticks; end
        end
        check("tmr_done_at_tick", 32'(done_tick), 32'd4);
        step(1);
        check("tmr_done_single", 32'(a_timer_done), 32'h0);
        check("tmr_alarm", 32'({a_tmr_hi, a_tmr_lo, a_timer_running, a_timer_alarm}), 32'({8'h00, 2'b01}));
        step(20);
        check("tmr_alarm_hold", 32'({a_tmr_hi, a_tmr_lo, a_timer_running, a_timer_alarm}), 32'({8'h00, 2'b01}));
        pulse_tmr(1'b0, 1'b1, 7'd0);
        check("tmr_cancel", 32'({a_tmr_hi, a_tmr_lo, a_timer_running, a_timer_alarm}), 32'h0);

        // edges, ticks frozen via set_mode
        set_mode = 1'b1;
        pulse_tmr(1'b1, 1'b0, 7'd120);
        check("tmr_clamp99", 32'({a_tmr_hi, a_tmr_lo, a_timer_running}), 32'({8'h99, 1'b1}));
        pulse_tmr(1'b1, 1'b0, 7'd0);
        check("tmr_zero_ignored", 32'({a_tmr_hi, a_tmr_lo, a_timer_running}), 32'({8'h99, 1'b1}));
        pulse_tmr(1'b1, 1'b1, 7'd5);
        check("tmr_cancel_prio", 32'({a_tmr_hi, a_tmr_lo, a_timer_running, a_timer_alarm}), 32'h0);
        set_mode = 1'b0;
        pulse_tmr(1'b1, 1'b0, 7'd5);
        step(6);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_mid_timer", 32'({a_tmr_hi, a_tmr_lo, a_timer_running, a_timer_alarm, a_sec_tick}), 32'h0);
        check("rst_mid_time", 32'({a_hour_hi, a_hour_lo, a_min_hi, a_min_lo}), 32'h0000);

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            onOff = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 99) == 0) set_mode = ~set_mode;
            inc_min  = ($urandom_range(0, 5) == 0);
            inc_hour = ($urandom_range(0, 7) == 0);
            timer_load = ($urandom_range(0, 59) == 0);
            timer_min = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(0, 127));
            timer_cancel = ($urandom_range(0, 199) == 0);
            reset = ($urandom_range(0, 999) == 0);
            step(1);
        end
        reset = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; timer_load = 1'b0; timer_cancel = 1'b0;
        step(2);
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
